// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 encrypt engine: FSM states, round count,
// round-constant lookup, GF(2^8) doubling and column-major byte addressing.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  localparam int unsigned NR = 10;

  // Round constant for rounds 1..10; anything else yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] value;
    case (round)
      4'd1:    value = 8'h01;
      4'd2:    value = 8'h02;
      4'd3:    value = 8'h04;
      4'd4:    value = 8'h08;
      4'd5:    value = 8'h10;
      4'd6:    value = 8'h20;
      4'd7:    value = 8'h40;
      4'd8:    value = 8'h80;
      4'd9:    value = 8'h1b;
      4'd10:   value = 8'h36;
      default: value = 8'h00;
    endcase
    return value;
  endfunction

  // Multiply by x (02) in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MSB position of the byte at (col,row); byte 0 occupies bits [127:120].
  function automatic int unsigned byte_msb(input int unsigned col, input int unsigned row);
    return 127 - 8 * (4 * col + row);
  endfunction

  // Fetch the byte at (col,row) from a 128-bit column-major block.
  function automatic logic [7:0] get_byte(input logic [127:0] blk, input int unsigned col,
                                          input int unsigned row);
    return blk[byte_msb(col, row) -: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational byte substitution.
module sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0 sits in the most significant byte so the table reads row by row.
  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX_TABLE[in_byte];

endmodule

// File: rtl/aes_enc_core.sv
// Iterative AES-128 encryption: one round per clock, round key derived on the
// fly from the previous one, valid/ready handshakes on both sides.
module aes_enc_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct_out
);

  fsm_state_t   state;
  fsm_state_t   state_next;
  logic [127:0] state_reg;
  logic [127:0] rk_reg;
  logic [3:0]   round;

  logic [127:0] sub_bytes;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [127:0] round_out;
  logic [127:0] rk_next;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  temp_word;
  logic [31:0]  w0_next;
  logic [31:0]  w1_next;
  logic [31:0]  w2_next;
  logic [31:0]  w3_next;
  logic         accept;
  logic         last_round;
  logic         round_valid;

  assign last_round  = (round == 4'(NR));
  assign round_valid = (round >= 4'd1) && (round <= 4'(NR));

  // SubBytes: one S-box per state byte.
  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    sbox u_sbox (
      .in_byte  (state_reg[127-8*i -: 8]),
      .out_byte (sub_bytes[127-8*i -: 8])
    );
  end

  // SubWord of the rotated last key word feeds the key schedule.
  assign rot_word = {rk_reg[23:0], rk_reg[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_sub_word
    sbox u_sbox (
      .in_byte  (rot_word[31-8*j -: 8]),
      .out_byte (sub_word[31-8*j -: 8])
    );
  end

  // ShiftRows: row r rotates left by r columns.
  always_comb begin
    shifted = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        shifted[byte_msb(c, r) -: 8] = get_byte(sub_bytes, (c + r) % 4, r);
      end
    end
  end

  // MixColumns: {02,03,01,01} circulant applied to each column.
  always_comb begin
    mixed = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      logic [7:0] a0;
      logic [7:0] a1;
      logic [7:0] a2;
      logic [7:0] a3;
      a0 = get_byte(shifted, c, 0);
      a1 = get_byte(shifted, c, 1);
      a2 = get_byte(shifted, c, 2);
      a3 = get_byte(shifted, c, 3);
      mixed[byte_msb(c, 0) -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mixed[byte_msb(c, 1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mixed[byte_msb(c, 2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mixed[byte_msb(c, 3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

  // KeyExpand: next round key from the current one and this round's rcon.
  always_comb begin
    temp_word = sub_word ^ {rcon(round), 24'h000000};
    w0_next   = rk_reg[127:96] ^ temp_word;
    w1_next   = rk_reg[95:64] ^ w0_next;
    w2_next   = rk_reg[63:32] ^ w1_next;
    w3_next   = rk_reg[31:0] ^ w2_next;
    rk_next   = {w0_next, w1_next, w2_next, w3_next};
    round_out = (last_round ? shifted : mixed) ^ rk_next;
  end

  // FSM next-state and handshake outputs; ct_out is only exposed in DONE.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    ct_out     = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (!round_valid) begin
          state_next = IDLE;
        end else if (last_round) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        ct_out    = state_reg;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: load on accept, then advance one round per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= '0;
      rk_reg    <= '0;
      round     <= '0;
    end else if (accept) begin
      state_reg <= pt_in ^ key_in;
      rk_reg    <= key_in;
      round     <= 4'd1;
    end else if (state == RUN && round_valid) begin
      state_reg <= round_out;
      rk_reg    <= rk_next;
      round     <= last_round ? round : round + 4'd1;
    end
  end

endmodule
